// File: rtl/reg_scoreboard_pkg.sv
// basicparams: shared scoreboard depth, instruction-id type and entry record
package basicparams;
  localparam int SB_DEPTH = 4;
  localparam int ID_W = 8;
  typedef logic [ID_W-1:0] IId;
  typedef struct packed {
    logic valid;
    logic [4:0] rd;
    IId id;
  } SbEntry;
endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: issue/writeback/flush/query bundle of the scoreboard
// master drives issue_*, wb_*, flush_*, rs*_addr, query_valid and reads the
// busy/stall/full/count/err status; slave is the scoreboard side.
interface reg_scoreboard_if
  import basicparams::*;
#(
  parameter int DEPTH = SB_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic issue_valid;
  logic issue_rf_wen;
  logic [4:0] issue_rd;
  IId issue_id;
  logic wb_valid;
  logic [4:0] wb_rd;
  logic flush_valid;
  logic [CW-1:0] flush_cnt;
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;
  logic query_valid;
  logic rs1_busy;
  logic rs2_busy;
  logic sb_stall;
  logic sb_full;
  logic [CW-1:0] sb_count;
  logic sb_err;
  modport master (
    output issue_valid, issue_rf_wen, issue_rd, issue_id, wb_valid, wb_rd,
           flush_valid, flush_cnt, rs1_addr, rs2_addr, query_valid,
    input  rs1_busy, rs2_busy, sb_stall, sb_full, sb_count, sb_err
  );
  modport slave (
    input  issue_valid, issue_rf_wen, issue_rd, issue_id, wb_valid, wb_rd,
           flush_valid, flush_cnt, rs1_addr, rs2_addr, query_valid,
    output rs1_busy, rs2_busy, sb_stall, sb_full, sb_count, sb_err
  );
endinterface

// File: rtl/reg_scoreboard_sb_match.sv
// sb_match: hit when a nonzero address equals the rd of any valid entry
// addr in 5, entries in DEPTH x SbEntry, hit out 1.
module sb_match
  import basicparams::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic [4:0] addr,
  input  SbEntry     entries [DEPTH],
  output logic       hit
);
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) hit = hit | (entries[i].valid && entries[i].rd == addr);
    hit = hit && (addr != '0);
  end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: in-order rd scoreboard with writeback pop and youngest-first flush
// clk, rst_n (async active-low) plain ports; everything else via sb (slave modport).
module reg_scoreboard
  import basicparams::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input logic clk,
  input logic rst_n,
  reg_scoreboard_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  SbEntry entries_q [DEPTH];
  SbEntry entries_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, after_pop, n_flush;
  logic err_q, err_d, full, do_pop, want_push, push;
  always_comb begin
    full = count_q == CW'(DEPTH);
    do_pop = sb.wb_valid && count_q != '0;
    want_push = sb.issue_valid && sb.issue_rf_wen && sb.issue_rd != '0 && !sb.flush_valid;
    push = want_push && !full;
    after_pop = count_q - CW'(do_pop);
    // flush happens after the pop and can never remove more than remains
    n_flush = sb.flush_valid ? (sb.flush_cnt < after_pop ? sb.flush_cnt : after_pop) : '0;
    count_d = after_pop - n_flush + CW'(push);
    head_d = head_q + PW'(do_pop);
    tail_d = tail_q - PW'(n_flush) + PW'(push);
    err_d = err_q | (want_push && full)
          | (sb.wb_valid && (count_q == '0 || sb.wb_rd != entries_q[head_q].rd));
    entries_d = entries_q;
    // slot i is among the n_flush youngest when its distance behind tail is < n_flush
    for (int i = 0; i < DEPTH; i++)
      if (CW'(PW'(tail_q - PW'(i) - PW'(1))) < n_flush) entries_d[i].valid = 1'b0;
    if (do_pop) entries_d[head_q].valid = 1'b0;
    if (push) entries_d[tail_q] = '{valid: 1'b1, rd: sb.issue_rd, id: sb.issue_id};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      entries_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      err_q <= 1'b0;
    end else begin
      entries_q <= entries_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      err_q <= err_d;
    end
  sb_match #(.DEPTH(DEPTH)) u_rs1 (.addr(sb.rs1_addr), .entries(entries_q), .hit(sb.rs1_busy));
  sb_match #(.DEPTH(DEPTH)) u_rs2 (.addr(sb.rs2_addr), .entries(entries_q), .hit(sb.rs2_busy));
  assign sb.sb_stall = sb.query_valid && (sb.rs1_busy || sb.rs2_busy);
  assign sb.sb_full = full;
  assign sb.sb_count = count_q;
  assign sb.sb_err = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed self-checking bench for reg_scoreboard (DEPTH=4)
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  reg_scoreboard_if #(.DEPTH(4)) sb_if ();
  reg_scoreboard #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .sb(sb_if.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
    sb_if.issue_valid = 0; sb_if.issue_rf_wen = 0; sb_if.issue_rd = 0; sb_if.issue_id = 0;
    sb_if.wb_valid = 0; sb_if.wb_rd = 0; sb_if.flush_valid = 0; sb_if.flush_cnt = 0;
    #1;
  endtask
  task automatic step(input logic iv, input logic wen, input logic [4:0] rd,
                      input logic wv, input logic [4:0] wrd, input logic fv, input logic [2:0] fc);
    sb_if.issue_valid = iv; sb_if.issue_rf_wen = wen; sb_if.issue_rd = rd; sb_if.issue_id = {3'd0, rd};
    sb_if.wb_valid = wv; sb_if.wb_rd = wrd; sb_if.flush_valid = fv; sb_if.flush_cnt = fc;
    cyc();
  endtask
  task automatic q(input logic [4:0] a1, input logic [4:0] a2);
    sb_if.rs1_addr = a1; sb_if.rs2_addr = a2; sb_if.query_valid = 1'b1;
    #1;
  endtask
  initial begin
    sb_if.issue_valid = 0; sb_if.issue_rf_wen = 0; sb_if.issue_rd = 0; sb_if.issue_id = 0;
    sb_if.wb_valid = 0; sb_if.wb_rd = 0; sb_if.flush_valid = 0; sb_if.flush_cnt = 0;
    sb_if.rs1_addr = 5; sb_if.rs2_addr = 5; sb_if.query_valid = 1;
    #3;
    chk("rst_count", 32'(sb_if.sb_count), 0);
    chk("rst_full", 32'(sb_if.sb_full), 0);
    chk("rst_busy1", 32'(sb_if.rs1_busy), 0);
    chk("rst_busy2", 32'(sb_if.rs2_busy), 0);
    chk("rst_stall", 32'(sb_if.sb_stall), 0);
    chk("rst_err", 32'(sb_if.sb_err), 0);
    #9 rst_n = 1'b1;
    cyc();
    // issue rd=5, busy one cycle later
    step(1, 1, 5, 0, 0, 0, 0);
    q(5, 0);
    chk("iss_busy", 32'(sb_if.rs1_busy), 1);
    chk("iss_stall", 32'(sb_if.sb_stall), 1);
    chk("iss_count", 32'(sb_if.sb_count), 1);
    // still busy during the writeback cycle, clear after
    sb_if.wb_valid = 1; sb_if.wb_rd = 5;
    #1;
    chk("wb_same_busy", 32'(sb_if.rs1_busy), 1);
    cyc();
    chk("wb_after_busy", 32'(sb_if.rs1_busy), 0);
    chk("wb_after_stall", 32'(sb_if.sb_stall), 0);
    chk("wb_after_count", 32'(sb_if.sb_count), 0);
    chk("wb_after_err", 32'(sb_if.sb_err), 0);
    // fill to DEPTH
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 2, 0, 0, 0, 0);
    step(1, 1, 3, 0, 0, 0, 0);
    step(1, 1, 4, 0, 0, 0, 0);
    q(4, 1);
    chk("fill_full", 32'(sb_if.sb_full), 1);
    chk("fill_count", 32'(sb_if.sb_count), 4);
    chk("fill_busy4", 32'(sb_if.rs1_busy), 1);
    chk("fill_busy1", 32'(sb_if.rs2_busy), 1);
    // overflow is refused and flagged
    step(1, 1, 6, 0, 0, 0, 0);
    q(6, 0);
    chk("ovf_err", 32'(sb_if.sb_err), 1);
    chk("ovf_count", 32'(sb_if.sb_count), 4);
    chk("ovf_busy6", 32'(sb_if.rs1_busy), 0);
    // full + writeback still refuses the push
    step(1, 1, 6, 1, 1, 0, 0);
    q(6, 1);
    chk("fullwb_count", 32'(sb_if.sb_count), 3);
    chk("fullwb_full", 32'(sb_if.sb_full), 0);
    chk("fullwb_busy6", 32'(sb_if.rs1_busy), 0);
    chk("fullwb_busy1", 32'(sb_if.rs2_busy), 0);
    q(2, 3);
    chk("fullwb_busy2", 32'(sb_if.rs1_busy), 1);
    chk("fullwb_busy3", 32'(sb_if.rs2_busy), 1);
    // async reset between edges with 3 pending entries
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(sb_if.sb_count), 0);
    chk("arst_busy1", 32'(sb_if.rs1_busy), 0);
    chk("arst_busy2", 32'(sb_if.rs2_busy), 0);
    chk("arst_err", 32'(sb_if.sb_err), 0);
    chk("arst_stall", 32'(sb_if.sb_stall), 0);
    rst_n = 1'b1;
    cyc();
    // flush 2 + writeback of head empties {7,8,9}; the issue is suppressed
    step(1, 1, 7, 0, 0, 0, 0);
    step(1, 1, 8, 0, 0, 0, 0);
    step(1, 1, 9, 0, 0, 0, 0);
    step(1, 1, 10, 1, 7, 1, 2);
    q(8, 10);
    chk("fl2_count", 32'(sb_if.sb_count), 0);
    chk("fl2_busy8", 32'(sb_if.rs1_busy), 0);
    chk("fl2_busy10", 32'(sb_if.rs2_busy), 0);
    chk("fl2_err", 32'(sb_if.sb_err), 0);
    // flush 1 without writeback drops only rd=9 (tail wraps here)
    step(1, 1, 7, 0, 0, 0, 0);
    step(1, 1, 8, 0, 0, 0, 0);
    step(1, 1, 9, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    q(9, 7);
    chk("fl1_count", 32'(sb_if.sb_count), 2);
    chk("fl1_busy9", 32'(sb_if.rs1_busy), 0);
    chk("fl1_busy7", 32'(sb_if.rs2_busy), 1);
    q(8, 0);
    chk("fl1_busy8", 32'(sb_if.rs1_busy), 1);
    // issue after the flush lands where rd=9 was; then drain in order
    step(1, 1, 11, 0, 0, 0, 0);
    step(0, 0, 0, 1, 7, 0, 0);
    step(0, 0, 0, 1, 8, 0, 0);
    q(11, 8);
    chk("refill_count", 32'(sb_if.sb_count), 1);
    chk("refill_busy11", 32'(sb_if.rs1_busy), 1);
    chk("refill_busy8", 32'(sb_if.rs2_busy), 0);
    chk("refill_err", 32'(sb_if.sb_err), 0);
    // oversized flush is clamped to the count
    step(0, 0, 0, 0, 0, 1, 4);
    q(11, 0);
    chk("flbig_count", 32'(sb_if.sb_count), 0);
    chk("flbig_busy", 32'(sb_if.rs1_busy), 0);
    // x0 and no-write issues push nothing
    step(1, 1, 0, 0, 0, 0, 0);
    chk("x0_count", 32'(sb_if.sb_count), 0);
    step(1, 0, 3, 0, 0, 0, 0);
    q(3, 0);
    chk("nowen_count", 32'(sb_if.sb_count), 0);
    chk("nowen_busy3", 32'(sb_if.rs1_busy), 0);
    step(1, 1, 12, 0, 0, 0, 0);
    q(0, 0);
    chk("rs0_stall", 32'(sb_if.sb_stall), 0);
    chk("rs0_busy", 32'(sb_if.rs1_busy), 0);
    step(0, 0, 0, 1, 12, 0, 0);
    // wrap-around: back-to-back issue+wb keeps count at 1
    step(1, 1, 1, 0, 0, 0, 0);
    for (int k = 2; k <= 10; k++) begin
      step(1, 1, 5'(k), 1, 5'(k - 1), 0, 0);
      q(5'(k), 5'(k - 1));
      chk($sformatf("wrap_count_%0d", k), 32'(sb_if.sb_count), 1);
      chk($sformatf("wrap_busy_new_%0d", k), 32'(sb_if.rs1_busy), 1);
      chk($sformatf("wrap_busy_old_%0d", k), 32'(sb_if.rs2_busy), 0);
    end
    step(0, 0, 0, 1, 10, 0, 0);
    chk("wrap_end_count", 32'(sb_if.sb_count), 0);
    chk("wrap_end_err", 32'(sb_if.sb_err), 0);
    // mismatched writeback still pops but flags
    step(1, 1, 5, 0, 0, 0, 0);
    step(0, 0, 0, 1, 6, 0, 0);
    q(5, 0);
    chk("wbmis_count", 32'(sb_if.sb_count), 0);
    chk("wbmis_busy", 32'(sb_if.rs1_busy), 0);
    chk("wbmis_err", 32'(sb_if.sb_err), 1);
    // writeback when empty flags and pops nothing
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    cyc();
    chk("wbempty_pre_err", 32'(sb_if.sb_err), 0);
    step(0, 0, 0, 1, 3, 0, 0);
    chk("wbempty_err", 32'(sb_if.sb_err), 1);
    chk("wbempty_count", 32'(sb_if.sb_count), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

In-order destination-register scoreboard for the integer pipeline. It records the `rd` of every register-writing instruction that leaves the data-select stage, and holds it until that instruction writes back. It tells the data-select stage whether `rs1`/`rs2` of the instruction it currently holds is still pending. Its second purpose is to sequence stalls independently of the per-stage forwarding bundles. On a branch/trap flush it rolls back the youngest in-flight entries.

## Interface
Parameters:
- `DEPTH`, 4: maximum in-flight register-writing instructions; power of two, 2..16.

Ports:
- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  instruction leaves data-select this cycle (`ds_exe_valid`).
- `issue_rf_wen`  in  1  instruction writes the register file.
- `issue_rd`  in  5  destination register.
- `issue_id`  in  IId  instruction id, stored with the entry.
- `wb_valid`  in  1  writeback of the oldest entry this cycle.
- `wb_rd`  in  5  writeback destination, checked against the head entry.
- `flush_valid`  in  1  roll back the youngest entries.
- `flush_cnt`  in  $clog2(DEPTH)+1  number of youngest entries to discard.
- `rs1_addr`, `rs2_addr`  in  5 each  sources of the instruction held in data-select.
- `query_valid`  in  1  data-select holds a valid instruction.
- `rs1_busy`, `rs2_busy`  out  1 each  the source matches a pending entry.
- `sb_stall`  out  1  `query_valid && (rs1_busy || rs2_busy)`.
- `sb_full`  out  1  count == DEPTH.
- `sb_count`  out  $clog2(DEPTH)+1  number of valid entries.
- `sb_err`  out  1  sticky protocol-error flag.

## Operation
- Storage is a circular FIFO of `DEPTH` entries {valid, rd, id}, with head pointer, tail pointer and count.
- **Issue.** An entry is pushed only when `issue_valid && issue_rf_wen && issue_rd != 0 && !sb_full && !flush_valid`.
  - An issue with `rd == 0`, or with `rf_wen == 0`, pushes nothing.
  - An issue while full pushes nothing and sets `sb_err`. Upstream must gate issue with `sb_full`.
- **Writeback.** `wb_valid` pops the head entry.
  - `wb_valid` when empty sets `sb_err` and pops nothing.
  - `wb_rd != head.rd` sets `sb_err`, but the head is still popped.
- **Busy.** `rsX_busy` = `rsX_addr != 0` and any valid entry has `rd == rsX_addr`. This is a pure function of the registered FIFO state.
- **Flush.** Evaluation order within one cycle:
  1. Writeback pops the head.
  2. Flush removes `min(flush_cnt, count_after_pop)` entries from the tail; the tail pointer moves back by that amount, modulo DEPTH.
  3. Issue is suppressed.
- **Simultaneous issue and writeback** with neither full nor empty: the count is unchanged, and both pointers advance.
- **Full with simultaneous writeback:** the push is still refused, because `sb_full` is taken from registered state.
- Pointers wrap modulo DEPTH. `count` saturates at neither end; the error cases above prevent overflow and underflow.

## Timing
- **Reset values:** all entries invalid; head = tail = 0; `sb_count` = 0; `sb_full` = 0; `rs1_busy` = `rs2_busy` = 0; `sb_stall` = 0; `sb_err` = 0.
- **Reset mid-operation:** outputs clear immediately (asynchronous reset), and no pending entries survive.
- **Issue-to-busy latency:** 1 cycle. An entry pushed at edge N is visible in `rsX_busy` after edge N.
- **Writeback-to-clear latency:** 1 cycle. In the writeback cycle the entry is still busy; the data-select stage takes that value through its writeback forwarding path.
- `sb_stall` is combinational from `query_valid`, the source addresses and registered state; there is no additional delay.
- `sb_err` is set at the edge following the offending event and stays set until reset.

## Structure
- **Shared package (`basicparams`):** add `SB_DEPTH`, plus typedef `SbEntry` = struct packed {logic valid; logic [4:0] rd; IId id;}.
- **Sub-module `sb_match`:** combinational compare of one 5-bit address against all DEPTH entries, giving a 1-bit hit. It is instantiated twice, once for rs1 and once for rs2.
- FIFO pointers and count are kept in `reg_scoreboard` itself.

## Test plan
- **Reset, then issue, then writeback.** Reset, then issue rd=5. Next cycle `rs1_addr`=5 with query_valid gives `rs1_busy`=1 and `sb_stall`=1. `wb_valid` with wb_rd=5 leaves busy=1 in that cycle and busy=0 the cycle after; `sb_count` returns to 0.
- **Fill and overflow.** Issue rd=1,2,3,4 with DEPTH=4, giving `sb_full`=1 and `sb_count`=4. Issuing rd=6 is ignored and sets `sb_err`=1, and rd=6 is not busy. Issuing rd=6 together with wb rd=1 on that full cycle also refuses the push.
- **Flush rollback.** Entries {7,8,9} in flight; flush_valid with flush_cnt=2 in the same cycle as wb_rd=7 leaves count=0. A separate run with flush_cnt=1 and no writeback leaves {7,8}, with rd=9 not busy.
- **x0 and no-write issues.** Issue rd=0, or rf_wen=0 with rd=3, leaves count unchanged. rs1=0 with query_valid never stalls.
- **Wrap-around.** 10 back-to-back issue+wb pairs on rd=1..10 keep count=1 throughout. The pointers wrap twice, and busy always tracks only the latest rd.
- **Async reset mid-flight.** With 3 entries pending, asserting `rst_n` low between edges clears `sb_count`, `rs1_busy`, `rs2_busy` and `sb_err` before the next edge.
